// File: rtl/issue_queue_shift.sv
// Collapsing issue queue: in-order slots, CDB wakeup, oldest-ready issue.
// Optional flush port and logic enabled by defining ISSUEQ_FLUSH_EN.
module issue_queue_shift #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef ISSUEQ_FLUSH_EN
  input  logic              flush_i,
`endif
  input  logic              dispatch_valid_i,
  output logic              dispatch_ready_o,
  input  logic [OP_W-1:0]   dispatch_opcode_i,
  input  logic [TAG_W-1:0]  dispatch_rd_tag_i,
  input  logic [TAG_W-1:0]  dispatch_rs1_tag_i,
  input  logic [TAG_W-1:0]  dispatch_rs2_tag_i,
  input  logic [DATA_W-1:0] dispatch_rs1_data_i,
  input  logic [DATA_W-1:0] dispatch_rs2_data_i,
  input  logic              dispatch_rs1_val_i,
  input  logic              dispatch_rs2_val_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              issue_valid_o,
  input  logic              issue_ready_i,
  output logic [OP_W-1:0]   issue_opcode_o,
  output logic [TAG_W-1:0]  issue_rd_tag_o,
  output logic [DATA_W-1:0] issue_rs1_data_o,
  output logic [DATA_W-1:0] issue_rs2_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              vld;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  rd;
    logic [TAG_W-1:0]  t1;
    logic [DATA_W-1:0] d1;
    logic              v1;
    logic [TAG_W-1:0]  t2;
    logic [DATA_W-1:0] d2;
    logic              v2;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  ent_t             new_e;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] wpos;
  logic [IDX_W-1:0] sel;
  logic             any_rdy;
  logic             issue_fire;
  logic             disp_fire;

  assign full_o           = (count_q == CNT_W'(DEPTH));
  assign empty_o          = (count_q == '0);
  assign count_o          = count_q;
  assign dispatch_ready_o = !full_o;
  assign disp_fire        = dispatch_valid_i && dispatch_ready_o;
  assign issue_fire       = any_rdy && issue_ready_i;

  always_comb begin
    any_rdy = 1'b0;
    sel     = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (ent_q[i].vld && ent_q[i].v1 && ent_q[i].v2) begin
        any_rdy = 1'b1;
        sel     = IDX_W'(i);
      end
    end
  end

  assign issue_valid_o    = any_rdy;
  assign issue_opcode_o   = any_rdy ? ent_q[sel].op : '0;
  assign issue_rd_tag_o   = any_rdy ? ent_q[sel].rd : '0;
  assign issue_rs1_data_o = any_rdy ? ent_q[sel].d1 : '0;
  assign issue_rs2_data_o = any_rdy ? ent_q[sel].d2 : '0;

  always_comb begin
    new_e     = '0;
    new_e.vld = 1'b1;
    new_e.op  = dispatch_opcode_i;
    new_e.rd  = dispatch_rd_tag_i;
    new_e.t1  = dispatch_rs1_tag_i;
    new_e.d1  = dispatch_rs1_data_i;
    new_e.v1  = dispatch_rs1_val_i;
    new_e.t2  = dispatch_rs2_tag_i;
    new_e.d2  = dispatch_rs2_data_i;
    new_e.v2  = dispatch_rs2_val_i;
  end

  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    wpos    = count_q;
    if (issue_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i >= int'(sel)) begin
          if (i == DEPTH-1) ent_d[i] = '0;
          else              ent_d[i] = ent_q[(i+1) % DEPTH];
        end
      end
      wpos = count_q - CNT_W'(1);
    end
    if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++)
        if (CNT_W'(i) == wpos) ent_d[i] = new_e;
    end
    // Wakeup runs on the post-shift image, so it also serves dispatch bypass.
    if (cdb_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_d[i].vld) begin
          if (!ent_d[i].v1 && ent_d[i].t1 == cdb_tag_i) begin
            ent_d[i].d1 = cdb_data_i;
            ent_d[i].v1 = 1'b1;
          end
          if (!ent_d[i].v2 && ent_d[i].t2 == cdb_tag_i) begin
            ent_d[i].d2 = cdb_data_i;
            ent_d[i].v2 = 1'b1;
          end
        end
      end
    end
    unique case ({disp_fire, issue_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
`ifdef ISSUEQ_FLUSH_EN
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      count_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_issue_queue_shift.sv
// Bench for issue_queue_shift: queue-based reference model plus directed cases.
// Flush case compiled in when ISSUEQ_FLUSH_EN is defined.
module tb_issue_queue_shift;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic        clk;
  logic        rst_n;
`ifdef ISSUEQ_FLUSH_EN
  logic        flush_i;
`endif
  logic        dv;
  logic        drdy;
  logic [3:0]  dop;
  logic [5:0]  drd, dt1, dt2;
  logic [31:0] dd1, dd2;
  logic        dv1, dv2;
  logic        cv;
  logic [5:0]  ctag;
  logic [31:0] cdata;
  logic        iv;
  logic        irdy;
  logic [3:0]  iop;
  logic [5:0]  ird;
  logic [31:0] id1, id2;
  logic [CW-1:0] cnt;
  logic        full, empty;

  issue_queue_shift #(.DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
`ifdef ISSUEQ_FLUSH_EN
    .flush_i             (flush_i),
`endif
    .dispatch_valid_i    (dv),
    .dispatch_ready_o    (drdy),
    .dispatch_opcode_i   (dop),
    .dispatch_rd_tag_i   (drd),
    .dispatch_rs1_tag_i  (dt1),
    .dispatch_rs2_tag_i  (dt2),
    .dispatch_rs1_data_i (dd1),
    .dispatch_rs2_data_i (dd2),
    .dispatch_rs1_val_i  (dv1),
    .dispatch_rs2_val_i  (dv2),
    .cdb_valid_i         (cv),
    .cdb_tag_i           (ctag),
    .cdb_data_i          (cdata),
    .issue_valid_o       (iv),
    .issue_ready_i       (irdy),
    .issue_opcode_o      (iop),
    .issue_rd_tag_o      (ird),
    .issue_rs1_data_o    (id1),
    .issue_rs2_data_o    (id2),
    .count_o             (cnt),
    .full_o              (full),
    .empty_o             (empty)
  );

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  rd, t1, t2;
    logic [31:0] d1, d2;
    bit          v1, v2;
  } m_t;

  m_t mq[$];
  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int first_rdy();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].v1 && mq[i].v2) return i;
    return -1;
  endfunction

  // Reference update at each rising edge, from the inputs held this cycle.
  task automatic model_step();
    int  k;
    bit  ifire, dfire;
    m_t  e;
    if (!rst_n) begin
      mq.delete();
      return;
    end
`ifdef ISSUEQ_FLUSH_EN
    if (flush_i) begin
      mq.delete();
      return;
    end
`endif
    k     = first_rdy();
    ifire = (k >= 0) && irdy;
    dfire = dv && (mq.size() < DEPTH);
    if (ifire) mq.delete(k);
    if (dfire) begin
      e.op = dop; e.rd = drd;
      e.t1 = dt1; e.d1 = dd1; e.v1 = dv1;
      e.t2 = dt2; e.d2 = dd2; e.v2 = dv2;
      mq.push_back(e);
    end
    if (cv) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (!mq[i].v1 && mq[i].t1 == ctag) begin
          mq[i].d1 = cdata; mq[i].v1 = 1;
        end
        if (!mq[i].v2 && mq[i].t2 == ctag) begin
          mq[i].d2 = cdata; mq[i].v2 = 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin : cmp
    int k;
    if (chk_en) begin
      k = first_rdy();
      chk("count", 64'(cnt), 64'(mq.size()));
      chk("full", 64'(full), 64'(mq.size() == DEPTH));
      chk("empty", 64'(empty), 64'(mq.size() == 0));
      chk("disp_ready", 64'(drdy), 64'(mq.size() != DEPTH));
      chk("issue_valid", 64'(iv), 64'(k >= 0));
      chk("issue_op", 64'(iop), (k >= 0) ? 64'(mq[k].op) : 64'd0);
      chk("issue_rd", 64'(ird), (k >= 0) ? 64'(mq[k].rd) : 64'd0);
      chk("issue_rs1", 64'(id1), (k >= 0) ? 64'(mq[k].d1) : 64'd0);
      chk("issue_rs2", 64'(id2), (k >= 0) ? 64'(mq[k].d2) : 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    chk_en = 1;
    #1;
  endtask

  task automatic idle();
    dv = 0; dop = 0; drd = 0; dt1 = 0; dt2 = 0;
    dd1 = 0; dd2 = 0; dv1 = 0; dv2 = 0;
    cv = 0; ctag = 0; cdata = 0; irdy = 0;
`ifdef ISSUEQ_FLUSH_EN
    flush_i = 0;
`endif
  endtask

  task automatic disp(input logic [3:0] op, input logic [5:0] rd,
                      input logic [5:0] t1, input logic [31:0] d1,
                      input logic v1, input logic [5:0] t2,
                      input logic [31:0] d2, input logic v2);
    dv = 1; dop = op; drd = rd;
    dt1 = t1; dd1 = d1; dv1 = v1;
    dt2 = t2; dd2 = d2; dv2 = v2;
  endtask

  task automatic nodisp();
    dv = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    do_reset();
    chk("rst count", 64'(cnt), 64'd0);
    chk("rst empty", 64'(empty), 64'd1);
    chk("rst ready", 64'(drdy), 64'd1);
    chk("rst ivalid", 64'(iv), 64'd0);

    // Fill with ready entries, hold issue
    for (int i = 1; i <= 4; i++) begin
      disp(4'(i), 6'(i + 32), 6'd0, 32'(i * 16), 1, 6'd0, 32'(i * 256), 1);
      tick();
    end
    nodisp();
    chk("fill count", 64'(cnt), 64'd4);
    chk("fill full", 64'(full), 64'd1);
    chk("fill dready", 64'(drdy), 64'd0);
    chk("fill op", 64'(iop), 64'd1);
    // Dispatch while full is refused even though issue fires
    disp(4'd9, 6'd1, 6'd0, 32'd0, 1, 6'd0, 32'd0, 1);
    irdy = 1;
    tick();
    nodisp();
    chk("full refuse count", 64'(cnt), 64'd3);
    chk("full refuse op", 64'(iop), 64'd2);
    tick(); tick(); tick();
    irdy = 0;
    chk("drain empty", 64'(empty), 64'd1);

    // Slot0 waits on tag 5, slot1 ready
    do_reset();
    disp(4'hA, 6'd10, 6'd5, 32'd0, 0, 6'd0, 32'h11, 1); tick();
    disp(4'hB, 6'd11, 6'd0, 32'h21, 1, 6'd0, 32'h22, 1); tick();
    disp(4'hC, 6'd12, 6'd0, 32'h31, 1, 6'd0, 32'h32, 1); tick();
    disp(4'hD, 6'd13, 6'd0, 32'h41, 1, 6'd9, 32'd0, 0); tick();
    nodisp();
    chk("skip op", 64'(iop), 64'hB);
    irdy = 1; tick(); irdy = 0;
    chk("collapse count", 64'(cnt), 64'd3);
    chk("collapse op", 64'(iop), 64'hC);
    cv = 1; ctag = 6'd5; cdata = 32'h1234; tick(); cv = 0;
    chk("older wins op", 64'(iop), 64'hA);
    chk("older wins rs1", 64'(id1), 64'h1234);
    cv = 1; ctag = 6'd9; cdata = 32'h99; irdy = 1; tick();
    cv = 0; tick(); tick(); tick();
    irdy = 0;

    // Full-width tag compare and CDB wakeup
    do_reset();
    cv = 1; ctag = 6'h12; cdata = 32'h5; tick(); cv = 0;
    disp(4'h3, 6'd20, 6'h12, 32'd0, 0, 6'd0, 32'h77, 1); tick();
    nodisp();
    cv = 1; ctag = 6'h32; cdata = 32'hBAD; tick(); cv = 0;
    chk("alias no wake", 64'(iv), 64'd0);
    cv = 1; ctag = 6'h12; cdata = 32'hDEADBEEF; tick(); cv = 0;
    chk("wake valid", 64'(iv), 64'd1);
    chk("wake rs1", 64'(id1), 64'hDEADBEEF);

    // Dispatch bypass on rs2
    do_reset();
    disp(4'h6, 6'd21, 6'd0, 32'h1, 1, 6'h07, 32'd0, 0);
    cv = 1; ctag = 6'h07; cdata = 32'h55; tick();
    nodisp(); cv = 0;
    chk("bypass valid", 64'(iv), 64'd1);
    chk("bypass rs2", 64'(id2), 64'h55);

    // Both sources wake on one broadcast
    do_reset();
    disp(4'h7, 6'd22, 6'h20, 32'd0, 0, 6'h20, 32'd0, 0); tick();
    nodisp();
    cv = 1; ctag = 6'h20; cdata = 32'hCAFE; tick(); cv = 0;
    chk("dual rs1", 64'(id1), 64'hCAFE);
    chk("dual rs2", 64'(id2), 64'hCAFE);

    // Simultaneous issue and dispatch at count 2
    do_reset();
    disp(4'h1, 6'd1, 6'd0, 32'h1, 1, 6'd0, 32'h2, 1); tick();
    disp(4'h2, 6'd2, 6'd0, 32'h3, 1, 6'd0, 32'h4, 1); tick();
    disp(4'h3, 6'd3, 6'd0, 32'h5, 1, 6'd0, 32'h6, 1);
    irdy = 1; tick();
    nodisp();
    chk("swap count", 64'(cnt), 64'd2);
    chk("swap op", 64'(iop), 64'h2);
    tick(); irdy = 0;
    chk("swap slot1 op", 64'(iop), 64'h3);
    chk("swap slot1 rs2", 64'(id2), 64'h6);

`ifdef ISSUEQ_FLUSH_EN
    do_reset();
    for (int i = 0; i < 4; i++) begin
      disp(4'(i + 4), 6'(i), 6'd0, 32'(i), 1, 6'd0, 32'(i), 1);
      tick();
    end
    disp(4'hF, 6'd5, 6'd0, 32'd0, 1, 6'd0, 32'd0, 1);
    flush_i = 1; tick(); flush_i = 0;
    nodisp();
    chk("flush count", 64'(cnt), 64'd0);
    chk("flush empty", 64'(empty), 64'd1);
    chk("flush ivalid", 64'(iv), 64'd0);
`endif

    // Reset mid-operation discards entries
    disp(4'h8, 6'd8, 6'd0, 32'h8, 1, 6'd0, 32'h8, 1); tick();
    nodisp();
    do_reset();
    chk("midrst count", 64'(cnt), 64'd0);
    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
